// File: rtl/gate_truth_checker.sv
// rtl/gate_truth_checker.sv - in-circuit stimulus/response truth-table checker for a 2-input gate
module gate_truth_checker #(
    parameter logic [3:0] TRUTH         = 4'b1001,
    parameter int         SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       y,
    output logic       a,
    output logic       b,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [3:0] fail_mask
);

    typedef enum logic [2:0] {IDLE, APPLY, SETTLE, SAMPLE, DONE} state_t;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);

    state_t     state;
    state_t     state_nxt;
    logic [1:0] idx;
    logic [1:0] idx_nxt;
    logic [3:0] settle_cnt;
    logic       launch;
    logic       mismatch;

    assign launch   = start && (state == IDLE || state == DONE);
    assign mismatch = (y != TRUTH[idx]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = APPLY;
            APPLY:   state_nxt = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;
            SETTLE:  if (settle_cnt <= 4'd1) state_nxt = SAMPLE;
            SAMPLE:  state_nxt = (idx == 2'd3) ? DONE : APPLY;
            DONE:    if (start) state_nxt = APPLY;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            APPLY, SETTLE, SAMPLE: busy = 1'b1;
            DONE:                  done = 1'b1;
            default:               ;
        endcase
    end

    always_comb begin
        idx_nxt = idx;
        if (launch) begin
            idx_nxt = 2'd0;
        end else if (state == SAMPLE && idx != 2'd3) begin
            idx_nxt = idx + 2'd1;
        end
    end

    // a/b are loaded with the vector the next state will present, so they are clean flop outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx        <= 2'd0;
            settle_cnt <= 4'd0;
            err_count  <= 3'd0;
            fail_mask  <= 4'd0;
            pass       <= 1'b0;
            a          <= 1'b0;
            b          <= 1'b0;
        end else begin
            idx <= idx_nxt;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        err_count <= 3'd0;
                        fail_mask <= 4'd0;
                        pass      <= 1'b0;
                    end
                end
                APPLY:  settle_cnt <= SETTLE_LOAD;
                SETTLE: settle_cnt <= settle_cnt - 4'd1;
                SAMPLE: begin
                    if (mismatch) begin
                        err_count      <= err_count + 3'd1;
                        fail_mask[idx] <= 1'b1;
                    end
                    if (idx == 2'd3) begin
                        pass <= (err_count == 3'd0) && !mismatch;
                    end
                end
                default: ;
            endcase
            if (state_nxt == APPLY || state_nxt == SETTLE || state_nxt == SAMPLE) begin
                a <= idx_nxt[1];
                b <= idx_nxt[0];
            end else begin
                a <= 1'b0;
                b <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_gate_truth_checker.sv
// tb/tb_gate_truth_checker.sv - scoreboard bench for gate_truth_checker (default and zero-settle instances)
module tb_gate_truth_checker;

    localparam logic [3:0] XNOR_TT = 4'b1001;

    typedef struct {
        logic [2:0] err;
        logic [3:0] mask;
        logic       pass;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start0, start1;
    logic       y0, y1;
    logic       a0, b0, busy0, done0, pass0;
    logic       a1, b1, busy1, done1, pass1;
    logic [2:0] err0, err1;
    logic [3:0] mask0, mask1;
    int         mode;
    logic       glitch;
    int         errors = 0;
    int         checks = 0;
    exp_t       sb[$];

    always #5 clk = ~clk;

    always_comb begin
        case (mode)
            0:       y0 = ~(a0 ^ b0);
            1:       y0 = 1'b0;
            default: y0 = a0 ^ b0;
        endcase
    end

    assign y1 = ~(a1 ^ b1) ^ glitch;

    gate_truth_checker dut0 (
        .clk(clk), .rst(rst), .start(start0), .y(y0),
        .a(a0), .b(b0), .busy(busy0), .done(done0), .pass(pass0),
        .err_count(err0), .fail_mask(mask0)
    );

    gate_truth_checker #(.TRUTH(4'b1001), .SETTLE_CYCLES(0)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .y(y1),
        .a(a1), .b(b1), .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .fail_mask(mask1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic gate_model(input int m, input int v);
        logic [1:0] ab;
        ab = 2'(v);
        case (m)
            0:       return ~(ab[1] ^ ab[0]);
            1:       return 1'b0;
            default: return ab[1] ^ ab[0];
        endcase
    endfunction

    task automatic push_exp(input int m);
        exp_t e;
        e.err  = 3'd0;
        e.mask = 4'd0;
        for (int i = 0; i < 4; i++) begin
            if (gate_model(m, i) != XNOR_TT[i]) begin
                e.mask[i] = 1'b1;
                e.err     = e.err + 3'd1;
            end
        end
        e.pass = (e.err == 3'd0);
        sb.push_back(e);
    endtask

    task automatic pop_check(input string tag, input logic [2:0] err, input logic [3:0] mask,
                             input logic p);
        exp_t e;
        checks++;
        assert (sb.size() != 0) else begin
            errors++;
            $error("FAIL %s_sb observed=empty expected=entry", tag);
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, "_err"}, 32'(err), 32'(e.err));
            chk({tag, "_mask"}, 32'(mask), 32'(e.mask));
            chk({tag, "_pass"}, 32'(p), 32'(e.pass));
        end
    endtask

    // Called at E0+1ns: checks the 16-cycle vector walk, then the DONE results at E0+16.
    task automatic watch0(input string tag);
        for (int k = 0; k < 16; k++) begin
            chk({tag, "_busy"}, 32'(busy0), 32'd1);
            chk({tag, "_done_low"}, 32'(done0), 32'd0);
            chk({tag, "_ab"}, 32'({a0, b0}), 32'(k / 4));
            tick();
        end
        chk({tag, "_done"}, 32'(done0), 32'd1);
        chk({tag, "_busy_end"}, 32'(busy0), 32'd0);
        chk({tag, "_ab_end"}, 32'({a0, b0}), 32'd0);
        pop_check(tag, err0, mask0, pass0);
    endtask

    task automatic run0(input string tag, input int m);
        mode = m;
        push_exp(m);
        @(negedge clk);
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        watch0(tag);
    endtask

    initial begin
        rst    = 1'b1;
        start0 = 1'b0;
        start1 = 1'b0;
        mode   = 0;
        glitch = 1'b0;
        #1;
        chk("rst_ab", 32'({a0, b0}), 32'd0);
        chk("rst_flags", 32'({busy0, done0, pass0}), 32'd0);
        chk("rst_err", 32'(err0), 32'd0);
        chk("rst_mask", 32'(mask0), 32'd0);
        chk("rst_dut1", 32'({a1, b1, busy1, done1, pass1, err1, mask1}), 32'd0);
        repeat (2) tick();
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("idle_quiet", 32'({busy0, done0, a0, b0}), 32'd0);

        run0("xnor", 0);
        run0("stuck0", 1);
        run0("xor", 2);

        // Reset mid-run: asserted at E0+7, held two cycles.
        mode = 0;
        @(negedge clk);
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        repeat (7) tick();
        chk("midrun_busy", 32'(busy0), 32'd1);
        rst = 1'b1;
        #1;
        chk("midrun_rst_outs", 32'({a0, b0, busy0, done0, pass0}), 32'd0);
        chk("midrun_rst_res", 32'({err0, mask0}), 32'd0);
        repeat (2) tick();
        @(negedge clk);
        rst = 1'b0;
        repeat (3) tick();
        chk("post_rst_idle", 32'({busy0, done0}), 32'd0);
        run0("after_rst", 0);

        // Start held through a failing run, then a restart straight out of DONE.
        mode = 2;
        push_exp(2);
        @(negedge clk);
        start0 = 1'b1;
        tick();
        watch0("held");
        mode = 0;
        push_exp(0);
        tick();
        start0 = 1'b0;
        chk("restart_done_drop", 32'(done0), 32'd0);
        chk("restart_cleared", 32'({err0, mask0, pass0}), 32'd0);
        watch0("restart");

        // Zero settle: 2-cycle vectors; y glitches during APPLY only.
        push_exp(0);
        @(negedge clk);
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk("s0_busy", 32'(busy1), 32'd1);
            chk("s0_ab", 32'({a1, b1}), 32'(k / 2));
            glitch = (k % 2 == 0);
            tick();
        end
        glitch = 1'b0;
        chk("s0_done", 32'(done1), 32'd1);
        chk("s0_busy_end", 32'(busy1), 32'd0);
        pop_check("s0", err1, mask1, pass1);
        chk("s0_dut0_idle", 32'({busy0, done0}), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
